spi_slave: RTL and testbench

SPI responder for the soc32e board-level environment. It is the far end of the SoC's SPI master pins (`sclk`, `ss`, `mosi`, `miso`) and replaces the current `miso = mosi` loopback with a real peripheral model and synthesizable target. It oversamples the SPI pins in the local `clk` domain, runs mode 0 (CPOL=0, CPHA=0), MSB first, and presents single-word transmit/receive buffers to local logic.

---
 rtl/spi_slave.sv | 228 ++++++++++++++++++++++
 tb/tb_spi_slave.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave.sv
// ----------------------------------------------------------------------------
// spi_slave
// SPI mode-0 (CPOL=0, CPHA=0), MSB-first responder. The SPI pins are
// oversampled in the local clk domain; local logic sees one-word transmit
// and receive buffers.
//
// Ports
//   clk, reset            local clock, asynchronous active-low reset
//   sclk, ss, mosi        SPI pins from the master (asynchronous to clk)
//   miso, misoOe          registered slave-out data and its output enable
//   txData/txWrite/txReady  transmit buffer write port
//   rxData/rxValid/rxRead   receive buffer read port
//   rxOverrun             sticky: an unread word was overwritten
//   busy                  transfer active; this is the FSM state itself
//                         (0 = IDLE, 1 = ACTIVE)
//
// Handshakes: a tx word is accepted on a cycle where txWrite=1 and
// txReady=1; txWrite while txReady=0 is dropped. A received word is
// consumed on a cycle where rxRead=1 and rxValid=1; rxRead while
// rxValid=0 does nothing.
// ----------------------------------------------------------------------------
module spi_slave #(
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sclk,
    input  logic                  ss,
    input  logic                  mosi,
    output logic                  miso,
    output logic                  misoOe,
    input  logic [DATA_WIDTH-1:0] txData,
    input  logic                  txWrite,
    output logic                  txReady,
    output logic [DATA_WIDTH-1:0] rxData,
    output logic                  rxValid,
    input  logic                  rxRead,
    output logic                  rxOverrun,
    output logic                  busy
);

    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_e;

    state_e state_q, state_d;

    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] ss_sync_q, ss_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic                   sclk_prev_q, sclk_prev_d;
    logic                   ss_prev_q, ss_prev_d;

    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
    logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
    logic [DATA_WIDTH-1:0] tx_buf_q, tx_buf_d;
    logic                  tx_full_q, tx_full_d;
    logic                  done_q, done_d;
    logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
    logic                  rx_valid_q, rx_valid_d;
    logic                  rx_overrun_q, rx_overrun_d;
    logic                  miso_q, miso_d;
    logic                  miso_oe_q, miso_oe_d;

    logic sclk_s, ss_s, mosi_s;
    logic sclk_rise, sclk_fall, ss_rise, ss_fall;
    logic load_tx, shift_in, shift_out, clr_cnt;

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign ss_s      = ss_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign sclk_rise =  sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s &  sclk_prev_q;
    assign ss_rise   =  ss_s   & ~ss_prev_q;
    assign ss_fall   = ~ss_s   &  ss_prev_q;

    // FSM: state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (ss_fall) state_d = ACTIVE;
            ACTIVE:  if (ss_rise) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM: outputs. An ss rise wins over a coincident sclk edge.
    always_comb begin
        busy      = (state_q == ACTIVE);
        clr_cnt   = 1'b0;
        load_tx   = 1'b0;
        shift_in  = 1'b0;
        shift_out = 1'b0;
        case (state_q)
            IDLE: begin
                clr_cnt = ss_fall;
                load_tx = ss_fall;
            end
            ACTIVE: begin
                if (!ss_rise) begin
                    shift_in  = sclk_rise;
                    load_tx   = sclk_fall && (cnt_q == '0);
                    shift_out = sclk_fall && (cnt_q != '0);
                end
            end
            default: ;
        endcase
    end

    // Datapath next-state
    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
        ss_sync_d   = {ss_sync_q[SYNC_STAGES-2:0], ss};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
        sclk_prev_d = sclk_s;
        ss_prev_d   = ss_s;

        cnt_d = cnt_q;
        if (clr_cnt) begin
            cnt_d = '0;
        end else if (shift_in) begin
            cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
        end

        rx_shift_d = shift_in ? {rx_shift_q[DATA_WIDTH-2:0], mosi_s} : rx_shift_q;
        // Word completes on the rise that wraps the counter; published next cycle.
        done_d = shift_in && (cnt_q == CNT_LAST);

        tx_shift_d = tx_shift_q;
        if (load_tx) begin
            tx_shift_d = tx_full_q ? tx_buf_q : '0;
        end else if (shift_out) begin
            tx_shift_d = tx_shift_q << 1;
        end

        // A load sees the pre-write buffer; a same-cycle write is held for the next frame.
        tx_buf_d  = tx_buf_q;
        tx_full_d = tx_full_q;
        if (load_tx) begin
            tx_full_d = 1'b0;
        end
        if (txWrite && !tx_full_q) begin
            tx_buf_d  = txData;
            tx_full_d = 1'b1;
        end

        rx_data_d    = rx_data_q;
        rx_valid_d   = rx_valid_q;
        rx_overrun_d = rx_overrun_q;
        if (rxRead && rx_valid_q) begin
            rx_valid_d   = 1'b0;
            rx_overrun_d = 1'b0;
        end
        if (done_q) begin
            rx_data_d  = rx_shift_q;
            rx_valid_d = 1'b1;
            if (rx_valid_q && !rxRead) begin
                rx_overrun_d = 1'b1;
            end
        end

        miso_oe_d = (state_q == ACTIVE);
        miso_d    = (state_q == ACTIVE) && tx_shift_q[DATA_WIDTH-1];
    end

    // The ss synchronizer resets low so that an ss already held low at
    // reset release is never seen as a fall; only a fresh fall starts a frame.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sclk_sync_q  <= '0;
            ss_sync_q    <= '0;
            mosi_sync_q  <= '0;
            sclk_prev_q  <= 1'b0;
            ss_prev_q    <= 1'b0;
            cnt_q        <= '0;
            rx_shift_q   <= '0;
            tx_shift_q   <= '0;
            tx_buf_q     <= '0;
            tx_full_q    <= 1'b0;
            done_q       <= 1'b0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            rx_overrun_q <= 1'b0;
            miso_q       <= 1'b0;
            miso_oe_q    <= 1'b0;
        end else begin
            sclk_sync_q  <= sclk_sync_d;
            ss_sync_q    <= ss_sync_d;
            mosi_sync_q  <= mosi_sync_d;
            sclk_prev_q  <= sclk_prev_d;
            ss_prev_q    <= ss_prev_d;
            cnt_q        <= cnt_d;
            rx_shift_q   <= rx_shift_d;
            tx_shift_q   <= tx_shift_d;
            tx_buf_q     <= tx_buf_d;
            tx_full_q    <= tx_full_d;
            done_q       <= done_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            rx_overrun_q <= rx_overrun_d;
            miso_q       <= miso_d;
            miso_oe_q    <= miso_oe_d;
        end
    end

    assign miso      = miso_q;
    assign misoOe    = miso_oe_q;
    assign txReady   = ~tx_full_q;
    assign rxData    = rx_data_q;
    assign rxValid   = rx_valid_q;
    assign rxOverrun = rx_overrun_q;

endmodule

// File: tb/tb_spi_slave.sv
// ----------------------------------------------------------------------------
// tb_spi_slave
// Self-checking bench for spi_slave (DATA_WIDTH=8, SYNC_STAGES=2). A task
// acts as the SPI master; expected master-received and slave-received words
// are queued when a frame is driven and compared when it completes.
// ----------------------------------------------------------------------------
module tb_spi_slave;

    localparam int DW = 8;
    localparam int SS = 2;
    localparam int H  = 8;  // sclk half period in clk cycles (>= SS+4)

    logic          clk = 1'b0;
    logic          reset;
    logic          sclk, ss, mosi;
    logic          miso, misoOe;
    logic [DW-1:0] txData;
    logic          txWrite, txReady;
    logic [DW-1:0] rxData;
    logic          rxValid, rxRead, rxOverrun, busy;

    logic [DW-1:0] exp_miso_q[$];
    logic [DW-1:0] exp_rx_q[$];
    int            n_checks = 0;
    int            n_fail   = 0;
    logic [DW-1:0] m_in;

    spi_slave #(.DATA_WIDTH(DW), .SYNC_STAGES(SS)) dut (
        .clk(clk), .reset(reset), .sclk(sclk), .ss(ss), .mosi(mosi),
        .miso(miso), .misoOe(misoOe), .txData(txData), .txWrite(txWrite),
        .txReady(txReady), .rxData(rxData), .rxValid(rxValid),
        .rxRead(rxRead), .rxOverrun(rxOverrun), .busy(busy)
    );

    // Clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
        $fatal(1, "watchdog");
    end

    // Checking
    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_master_rx(input string tag, input logic [DW-1:0] got);
        if (exp_miso_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s got=0x%0h exp=<empty queue>", tag, got);
        end else begin
            check_val(tag, {24'd0, got}, {24'd0, exp_miso_q.pop_front()});
        end
    endtask

    task automatic check_slave_rx(input string tag);
        if (exp_rx_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s got=0x%0h exp=<empty queue>", tag, rxData);
        end else begin
            check_val(tag, {24'd0, rxData}, {24'd0, exp_rx_q.pop_front()});
        end
    endtask

    // {miso, misoOe, busy, txReady, rxValid, rxOverrun} and rxData against reset values
    task automatic check_reset_vals(input string tag);
        check_val({tag, "_flags"}, {26'd0, miso, misoOe, busy, txReady, rxValid, rxOverrun},
                  32'b00_0100);
        check_val({tag, "_rxdata"}, {24'd0, rxData}, 32'd0);
    endtask

    // Drivers (all tasks start and end #1 after a rising clk edge)
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic write_tx(input logic [DW-1:0] d);
        txData  = d;
        txWrite = 1'b1;
        tick(1);
        txWrite = 1'b0;
    endtask

    task automatic read_rx();
        rxRead = 1'b1;
        tick(1);
        rxRead = 1'b0;
    endtask

    task automatic start_xfer();
        ss = 1'b0;
        tick(H);
    endtask

    task automatic end_xfer();
        tick(H);
        ss = 1'b1;
        tick(H);
    endtask

    // last_mode: 0 plain, 1 check rxValid latency, 2 pulse rxRead in the completion cycle
    task automatic spi_frame(input logic [DW-1:0] m_out, input int nbits, input int last_mode,
                             output logic [DW-1:0] got);
        got = '0;
        for (int i = 0; i < nbits; i++) begin
            mosi = m_out[DW-1-i];
            tick(H);
            got  = {got[DW-2:0], miso};
            sclk = 1'b1;
            if (i == nbits - 1 && last_mode == 1) begin
                tick(SS + 1);
                check_val("rx_valid_before_latency", {31'd0, rxValid}, 32'd0);
                tick(1);
                check_val("rx_valid_at_latency", {31'd0, rxValid}, 32'd1);
                tick(H - SS - 2);
            end else if (i == nbits - 1 && last_mode == 2) begin
                tick(SS + 1);
                rxRead = 1'b1;
                tick(1);
                rxRead = 1'b0;
                tick(H - SS - 2);
            end else begin
                tick(H);
            end
            sclk = 1'b0;
        end
    endtask

    task automatic full_frame(input string tag, input logic [DW-1:0] m_out,
                              input logic [DW-1:0] exp_m, input int last_mode);
        exp_miso_q.push_back(exp_m);
        exp_rx_q.push_back(m_out);
        spi_frame(m_out, DW, last_mode, m_in);
        check_master_rx({tag, "_master_rx"}, m_in);
        check_slave_rx({tag, "_rxdata"});
    endtask

    // Stimulus
    initial begin
        reset = 1'b0; sclk = 1'b0; ss = 1'b1; mosi = 1'b0;
        txData = '0; txWrite = 1'b0; rxRead = 1'b0;
        tick(4);
        reset = 1'b1;
        tick(6);
        check_reset_vals("reset");

        // sclk activity with ss high must be ignored
        for (int i = 0; i < 4; i++) begin
            sclk = 1'b1; tick(H);
            sclk = 1'b0; tick(H);
        end
        check_reset_vals("idle_sclk");

        // Single frame
        write_tx(8'hA5);
        check_val("tx_ready_after_write", {31'd0, txReady}, 32'd0);
        ss = 1'b0;
        tick(SS);
        check_val("tx_ready_before_load", {31'd0, txReady}, 32'd0);
        tick(1);
        check_val("tx_ready_at_load", {31'd0, txReady}, 32'd1);
        check_val("busy_at_start", {31'd0, busy}, 32'd1);
        tick(1);
        check_val("miso_oe_and_msb", {30'd0, misoOe, miso}, 32'b11);
        tick(H - SS - 2);
        full_frame("single", 8'h3C, 8'hA5, 1);
        end_xfer();
        check_val("single_end_flags", {29'd0, misoOe, busy, rxValid}, 32'b001);
        read_rx();
        check_val("single_read_clears", {31'd0, rxValid}, 32'd0);

        // Back-to-back frames, no second write
        write_tx(8'h81);
        start_xfer();
        full_frame("b2b_first", 8'h11, 8'h81, 0);
        full_frame("b2b_second", 8'h22, 8'h00, 0);
        end_xfer();
        check_val("b2b_overrun", {30'd0, rxValid, rxOverrun}, 32'b11);
        read_rx();
        check_val("b2b_read_clears", {30'd0, rxValid, rxOverrun}, 32'b00);

        // Abort after 5 bits
        start_xfer();
        spi_frame(8'hFF, 5, 0, m_in);
        end_xfer();
        check_val("abort_flags", {29'd0, rxValid, misoOe, busy}, 32'b000);
        start_xfer();
        full_frame("after_abort", 8'hF0, 8'h00, 0);
        end_xfer();
        read_rx();

        // rxRead coinciding with word completion
        start_xfer();
        full_frame("pre_read", 8'h12, 8'h00, 0);
        end_xfer();
        start_xfer();
        full_frame("read_at_done", 8'h34, 8'h00, 2);
        end_xfer();
        check_val("read_at_done_flags", {30'd0, rxValid, rxOverrun}, 32'b10);
        read_rx();

        // txWrite in the load cycle with an empty buffer
        ss = 1'b0;
        tick(SS);
        txData  = 8'h5A;
        txWrite = 1'b1;
        tick(1);
        txWrite = 1'b0;
        check_val("write_in_load_held", {31'd0, txReady}, 32'd0);
        tick(H - SS - 1);
        full_frame("load_write_cur", 8'h66, 8'h00, 0);
        full_frame("load_write_next", 8'h99, 8'h5A, 0);
        end_xfer();
        check_val("load_write_overrun", {30'd0, rxValid, rxOverrun}, 32'b11);
        read_rx();

        // Reset mid-frame with ss held low
        write_tx(8'h77);
        start_xfer();
        spi_frame(8'hFF, 3, 0, m_in);
        reset = 1'b0;
        #1;
        check_reset_vals("async_reset");
        tick(2);
        reset = 1'b1;
        tick(2 * H);
        check_reset_vals("post_reset_ss_low");
        spi_frame(8'hAA, DW, 0, m_in);
        check_val("no_frame_without_ss_fall", {29'd0, rxValid, busy, misoOe}, 32'b000);
        ss = 1'b1;
        tick(H);
        write_tx(8'hC3);
        start_xfer();
        full_frame("after_reset", 8'h5C, 8'hC3, 0);
        end_xfer();
        read_rx();

        // Random single frames
        for (int k = 0; k < 4; k++) begin
            logic [DW-1:0] d, m;
            d = DW'($urandom_range(0, 255));
            m = DW'($urandom_range(0, 255));
            write_tx(d);
            start_xfer();
            full_frame("random", m, d, 0);
            end_xfer();
            check_val("random_flags", {29'd0, rxValid, rxOverrun, txReady}, 32'b101);
            read_rx();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
